// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-port unified memory between the instruction
//            fetch port (i_*) and the load/store port (d_*). At most one
//            transaction is outstanding. Data wins over fetch unless data has
//            been granted STARVE_MAX times in a row while a fetch was waiting.
// Ports    : clk, n_rst        - clock, asynchronous active-low reset
//            i_req/i_addr      - fetch request in; i_gnt/i_rvalid/i_rdata out
//            d_req/d_we/d_be/d_addr/d_wdata - load/store request in;
//            d_gnt/d_rvalid/d_rdata out
//            m_req/m_we/m_be/m_addr/m_wdata - memory request out;
//            m_ready/m_rvalid/m_rdata in
//            proto_err         - sticky: response seen with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    // fetch port
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    // load/store port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    // memory port
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  proto_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT_I = 2'd1;
    localparam logic [1:0] c_WAIT_D = 2'd2;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0] r_state;
    logic [1:0] w_stateNext;
    logic [3:0] r_streak;
    logic       r_protoErr;

    logic w_idle;
    logic w_waitI;
    logic w_waitD;
    logic w_selD;
    logic w_selI;

    // Every output is qualified by n_rst so the whole interface reads zero
    // while reset is held, even though request inputs may still be active.
    assign w_idle  = n_rst & (r_state == c_IDLE);
    assign w_waitI = n_rst & (r_state == c_WAIT_I);
    assign w_waitD = n_rst & (r_state == c_WAIT_D);

    // Data has priority unless the fetch side has been starved long enough.
    assign w_selD = w_idle & d_req & (~i_req | (r_streak < c_STARVE_MAX));
    assign w_selI = w_idle & i_req & ~w_selD;

    assign m_req = w_selD | w_selI;
    assign d_gnt = w_selD & m_ready;
    assign i_gnt = w_selI & m_ready;

    assign i_rvalid = w_waitI & m_rvalid;
    assign d_rvalid = w_waitD & m_rvalid;
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

    assign proto_err = r_protoErr;

    // Memory-side request mux; fetches are always full-word reads.
    always_comb begin
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_selD) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (w_selI) begin
            m_be    = '1;
            m_addr  = i_addr;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (d_gnt) begin
                    w_stateNext = c_WAIT_D;
                end else if (i_gnt) begin
                    w_stateNext = c_WAIT_I;
                end
            end
            c_WAIT_I,
            c_WAIT_D: begin
                if (m_rvalid) begin
                    w_stateNext = c_IDLE;
                end
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Consecutive data grants taken while a fetch was waiting. Any fetch
    // grant, or any cycle without a pending fetch, ends the streak.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_streak <= 4'd0;
        end else if (!i_req || i_gnt) begin
            r_streak <= 4'd0;
        end else if (d_gnt && (r_streak < c_STARVE_MAX)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    // A response with nothing outstanding (e.g. a late reply to a
    // transaction killed by reset) is dropped and flagged until reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_protoErr <= 1'b0;
        end else if ((r_state == c_IDLE) && m_rvalid) begin
            r_protoErr <= 1'b1;
        end
    end

endmodule
`default_nettype wire
